// File: rtl/sq_fwd_unit.sv
// rtl/sq_fwd_unit.sv - store queue with byte-granular store-to-load forwarding
// Pointers carry a wrap MSB so full/empty and age ranges need no extra counters.
module sq_fwd_unit #(
  parameter int  DEPTH  = 8,
  parameter int  ADDR_W = 64,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dp_en_i,
  output logic [IDX_W:0]    sq_tail_o,
  output logic              sq_full_o,
  output logic              sq_empty_o,
  input  logic              st_vld_i,
  input  logic [IDX_W-1:0]  st_idx_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [63:0]       st_data_i,
  input  logic [7:0]        st_bm_i,
  input  logic              rob_st_retire_en_i,
  input  logic              br_recovery_i,
  input  logic [IDX_W:0]    br_tail_i,
  input  logic              ld_probe_i,
  input  logic [IDX_W:0]    ld_pos_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [7:0]        ld_bm_i,
  output logic              ld_iss_ok_o,
  output logic              fwd_hit_o,
  output logic [63:0]       fwd_data_o,
  output logic              fwd_conflict_o,
  output logic              st_req_o,
  output logic [ADDR_W-1:0] st_addr_o,
  output logic [63:0]       st_data_o,
  output logic [7:0]        st_bm_o,
  input  logic              st_ack_i
);

  logic [IDX_W:0]    head_q, head_d, commit_q, commit_d, tail_q, tail_d;
  logic [DEPTH-1:0]  addr_vld_q, addr_vld_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [63:0]       data_q [DEPTH];
  logic [63:0]       data_d [DEPTH];
  logic [7:0]        bm_q   [DEPTH];
  logic [7:0]        bm_d   [DEPTH];

  logic [IDX_W-1:0]  head_idx, tail_idx, ent_idx;
  logic [IDX_W:0]    ld_cnt;
  logic              found;
  logic [7:0]        sel_bm;
  logic [63:0]       sel_data, lane_mask;
  logic              covers;
  logic [2:0]        unused_ld_lo;

  assign head_idx     = head_q[IDX_W-1:0];
  assign tail_idx     = tail_q[IDX_W-1:0];
  assign unused_ld_lo = ld_addr_i[2:0];

  assign sq_tail_o  = tail_q;
  assign sq_empty_o = (head_q == tail_q);
  assign sq_full_o  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign st_req_o   = (head_q != commit_q);
  assign st_addr_o  = addr_q[head_idx];
  assign st_data_o  = data_q[head_idx];
  assign st_bm_o    = bm_q[head_idx];

  always_comb begin
    head_d     = head_q;
    commit_d   = commit_q;
    tail_d     = tail_q;
    addr_vld_d = addr_vld_q;
    addr_d     = addr_q;
    data_d     = data_q;
    bm_d       = bm_q;
    if (br_recovery_i) begin
      tail_d = br_tail_i;
    end else if (dp_en_i && !sq_full_o) begin
      addr_vld_d[tail_idx] = 1'b0;
      tail_d               = tail_q + (IDX_W+1)'(1);
    end
    if (rob_st_retire_en_i && (commit_q != tail_q)) begin
      commit_d = commit_q + (IDX_W+1)'(1);
    end
    if (st_ack_i && st_req_o) begin
      addr_vld_d[head_idx] = 1'b0;
      head_d               = head_q + (IDX_W+1)'(1);
    end
    // Applied last so an execute write beats a same-index dispatch clear.
    if (st_vld_i) begin
      addr_vld_d[st_idx_i] = 1'b1;
      addr_d[st_idx_i]     = st_addr_i;
      data_d[st_idx_i]     = st_data_i;
      bm_d[st_idx_i]       = st_bm_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      commit_q   <= '0;
      tail_q     <= '0;
      addr_vld_q <= '0;
    end else begin
      head_q     <= head_d;
      commit_q   <= commit_d;
      tail_q     <= tail_d;
      addr_vld_q <= addr_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    bm_q   <= bm_d;
  end

  assign ld_cnt = ld_pos_i - head_q;

  // Walk oldest to youngest from head; the last matching entry is the youngest older store.
  always_comb begin
    ld_iss_ok_o = 1'b1;
    found       = 1'b0;
    sel_bm      = '0;
    sel_data    = '0;
    ent_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_idx = head_idx + IDX_W'(k);
      if ((IDX_W+1)'(k) < ld_cnt) begin
        if (!addr_vld_q[ent_idx]) begin
          ld_iss_ok_o = 1'b0;
        end else if ((addr_q[ent_idx][ADDR_W-1:3] == ld_addr_i[ADDR_W-1:3]) &&
                     ((bm_q[ent_idx] & ld_bm_i) != 8'h00)) begin
          found    = 1'b1;
          sel_bm   = bm_q[ent_idx];
          sel_data = data_q[ent_idx];
        end
      end
    end
  end

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 8; b++) begin
      lane_mask[8*b +: 8] = {8{ld_bm_i[b]}};
    end
  end

  assign covers         = ((sel_bm & ld_bm_i) == ld_bm_i);
  assign fwd_hit_o      = ld_probe_i && found && covers;
  assign fwd_conflict_o = ld_probe_i && found && !covers;
  assign fwd_data_o     = fwd_hit_o ? (sel_data & lane_mask) : 64'h0;

endmodule

// File: tb/tb_sq_fwd_unit.sv
// tb/tb_sq_fwd_unit.sv - directed bench with an unbounded-counter store queue model
module tb_sq_fwd_unit;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 64;
  localparam int IDX_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              dp_en_i;
  logic [IDX_W:0]    sq_tail_o;
  logic              sq_full_o, sq_empty_o;
  logic              st_vld_i;
  logic [IDX_W-1:0]  st_idx_i;
  logic [ADDR_W-1:0] st_addr_i;
  logic [63:0]       st_data_i;
  logic [7:0]        st_bm_i;
  logic              rob_st_retire_en_i, br_recovery_i;
  logic [IDX_W:0]    br_tail_i;
  logic              ld_probe_i;
  logic [IDX_W:0]    ld_pos_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [7:0]        ld_bm_i;
  logic              ld_iss_ok_o, fwd_hit_o, fwd_conflict_o;
  logic [63:0]       fwd_data_o;
  logic              st_req_o;
  logic [ADDR_W-1:0] st_addr_o;
  logic [63:0]       st_data_o;
  logic [7:0]        st_bm_o;
  logic              st_ack_i;

  sq_fwd_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .dp_en_i(dp_en_i), .sq_tail_o(sq_tail_o),
    .sq_full_o(sq_full_o), .sq_empty_o(sq_empty_o), .st_vld_i(st_vld_i),
    .st_idx_i(st_idx_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_bm_i(st_bm_i),
    .rob_st_retire_en_i(rob_st_retire_en_i), .br_recovery_i(br_recovery_i),
    .br_tail_i(br_tail_i), .ld_probe_i(ld_probe_i), .ld_pos_i(ld_pos_i),
    .ld_addr_i(ld_addr_i), .ld_bm_i(ld_bm_i), .ld_iss_ok_o(ld_iss_ok_o),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o), .fwd_conflict_o(fwd_conflict_o),
    .st_req_o(st_req_o), .st_addr_o(st_addr_o), .st_data_o(st_data_o),
    .st_bm_o(st_bm_o), .st_ack_i(st_ack_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: head/commit/tail as ever-increasing store counts; slot = count % DEPTH.
  longint      hd, cm, tl;
  bit          m_vld [DEPTH];
  logic [63:0] m_addr [DEPTH];
  logic [63:0] m_data [DEPTH];
  logic [7:0]  m_bm [DEPTH];
  bit          m_full, m_ack, m_ret;

  initial begin
    hd = 0; cm = 0; tl = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_bm[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      hd = 0; cm = 0; tl = 0;
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
    end else begin
      m_full = ((tl - hd) == DEPTH);
      m_ack  = st_ack_i && (hd != cm);
      m_ret  = rob_st_retire_en_i && (cm != tl);
      if (br_recovery_i) begin
        tl = cm + ((longint'(br_tail_i) - cm) & 15);
      end else if (dp_en_i && !m_full) begin
        m_vld[tl % DEPTH] = 0;
        tl = tl + 1;
      end
      if (m_ret) cm = cm + 1;
      if (m_ack) begin
        m_vld[hd % DEPTH] = 0;
        hd = hd + 1;
      end
      if (st_vld_i) begin
        m_vld[st_idx_i]  = 1;
        m_addr[st_idx_i] = st_addr_i;
        m_data[st_idx_i] = st_data_i;
        m_bm[st_idx_i]   = st_bm_i;
      end
    end
  end

  longint      e_nold, e_slot;
  bit          e_iss, e_found, e_hit, e_conf;
  logic [63:0] e_data, e_mask;

  always @(negedge clk) begin
    if (!rst) begin
      chk("tail", 64'(sq_tail_o), 64'(tl & 15));
      chk("full", 64'(sq_full_o), 64'((tl - hd) == DEPTH));
      chk("empty", 64'(sq_empty_o), 64'(tl == hd));
      chk("st_req", 64'(st_req_o), 64'(hd != cm));
      if (hd != cm) begin
        chk("st_addr", st_addr_o, m_addr[hd % DEPTH]);
        chk("st_data", st_data_o, m_data[hd % DEPTH]);
        chk("st_bm", 64'(st_bm_o), 64'(m_bm[hd % DEPTH]));
      end
      e_nold = (longint'(ld_pos_i) - hd) & 15;
      e_iss = 1; e_found = 0; e_hit = 0; e_conf = 0; e_data = 0;
      for (longint k = e_nold - 1; k >= 0; k--) begin
        e_slot = (hd + k) % DEPTH;
        if (!m_vld[e_slot]) e_iss = 0;
        else if (!e_found && (m_addr[e_slot] >> 3) == (ld_addr_i >> 3) &&
                 (m_bm[e_slot] & ld_bm_i) != 0) begin
          e_found = 1;
          for (int b = 0; b < 8; b++) e_mask[8*b +: 8] = ld_bm_i[b] ? 8'hFF : 8'h00;
          if ((m_bm[e_slot] & ld_bm_i) == ld_bm_i) begin
            e_hit = ld_probe_i; e_data = ld_probe_i ? (m_data[e_slot] & e_mask) : 64'h0;
          end else begin
            e_conf = ld_probe_i;
          end
        end
      end
      chk("ld_iss_ok", 64'(ld_iss_ok_o), 64'(e_iss));
      chk("fwd_hit", 64'(fwd_hit_o), 64'(e_hit));
      chk("fwd_conflict", 64'(fwd_conflict_o), 64'(e_conf));
      chk("fwd_data", fwd_data_o, e_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dp_en_i = 0; st_vld_i = 0; rob_st_retire_en_i = 0; br_recovery_i = 0; st_ack_i = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic disp(input int n);
    for (int i = 0; i < n; i++) begin dp_en_i = 1; tick(); end
  endtask

  task automatic exec(input int idx, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    st_vld_i = 1; st_idx_i = IDX_W'(idx); st_addr_i = a; st_data_i = d; st_bm_i = m; tick();
  endtask

  task automatic retire(input int n);
    for (int i = 0; i < n; i++) begin rob_st_retire_en_i = 1; tick(); end
  endtask

  task automatic ack(input int n);
    for (int i = 0; i < n; i++) begin st_ack_i = 1; tick(); end
  endtask

  task automatic probe(input logic p, input logic [3:0] pos, input logic [63:0] a, input logic [7:0] m);
    ld_probe_i = p; ld_pos_i = pos; ld_addr_i = a; ld_bm_i = m; #1;
  endtask

  initial begin
    rst = 1; dp_en_i = 0; st_vld_i = 0; st_idx_i = 0; st_addr_i = 0; st_data_i = 0; st_bm_i = 0;
    rob_st_retire_en_i = 0; br_recovery_i = 0; br_tail_i = 0; ld_probe_i = 0; ld_pos_i = 0;
    ld_addr_i = 0; ld_bm_i = 0; st_ack_i = 0;

    do_reset();
    probe(1, 4'd0, 64'h100, 8'hFF);
    chk("rst_empty", 64'(sq_empty_o), 64'd1);
    chk("rst_full", 64'(sq_full_o), 64'd0);
    chk("rst_tail", 64'(sq_tail_o), 64'd0);
    chk("rst_req", 64'(st_req_o), 64'd0);
    chk("rst_iss_ok", 64'(ld_iss_ok_o), 64'd1);
    chk("rst_hit", 64'(fwd_hit_o), 64'd0);

    // Fill, overflow, full-range probe, drain, wrap
    disp(8);
    chk("fill_full", 64'(sq_full_o), 64'd1);
    chk("fill_tail", 64'(sq_tail_o), 64'h8);
    disp(1);
    chk("ninth_ignored", 64'(sq_tail_o), 64'h8);
    for (int i = 0; i < 8; i++) exec(i, 64'h1000 + 64'(8*i), 64'h0101010101010101 * 64'(i), 8'hFF);
    probe(1, 4'b1000, 64'h1038, 8'hFF);
    chk("all_older_hit", 64'(fwd_hit_o), 64'd1);
    chk("all_older_data", fwd_data_o, 64'h0707070707070707);
    probe(1, 4'b0000, 64'h1038, 8'hFF);
    chk("none_older_hit", 64'(fwd_hit_o), 64'd0);
    probe(0, 4'd0, 64'h0, 8'h00);
    retire(8);
    ack(8);
    chk("drained_empty", 64'(sq_empty_o), 64'd1);
    disp(3);
    chk("wrap_tail", 64'(sq_tail_o), 64'hB);
    chk("wrap_empty", 64'(sq_empty_o), 64'd0);
    chk("wrap_full", 64'(sq_full_o), 64'd0);

    // Youngest older store wins
    do_reset();
    disp(3);
    exec(0, 64'h100, 64'h1111111111111111, 8'hFF);
    exec(1, 64'h500, 64'h5555555555555555, 8'hFF);
    exec(2, 64'h100, 64'h2222222222222222, 8'hFF);
    probe(1, 4'd3, 64'h100, 8'h0F);
    chk("young_hit", 64'(fwd_hit_o), 64'd1);
    chk("young_data", fwd_data_o, 64'h0000000022222222);
    probe(1, 4'd2, 64'h104, 8'hF0);
    chk("older_data", fwd_data_o, 64'h1111111100000000);
    probe(0, 4'd0, 64'h0, 8'h00);

    // Partial overlap; dispatch and execute on the same slot in one cycle
    do_reset();
    dp_en_i = 1; st_vld_i = 1; st_idx_i = 0; st_addr_i = 64'h200; st_data_i = 64'hDEADBEEFCAFEF00D;
    st_bm_i = 8'h0F; tick();
    probe(1, 4'd1, 64'h200, 8'hFF);
    chk("same_slot_iss_ok", 64'(ld_iss_ok_o), 64'd1);
    chk("partial_conflict", 64'(fwd_conflict_o), 64'd1);
    chk("partial_hit", 64'(fwd_hit_o), 64'd0);
    probe(1, 4'd1, 64'h200, 8'hF0);
    chk("disjoint_conflict", 64'(fwd_conflict_o), 64'd0);
    chk("disjoint_hit", 64'(fwd_hit_o), 64'd0);
    probe(0, 4'd1, 64'h200, 8'h0F);
    chk("noprobe_hit", 64'(fwd_hit_o), 64'd0);
    probe(0, 4'd0, 64'h0, 8'h00);

    // Unknown addresses block issue; no same-cycle execute bypass
    do_reset();
    disp(3);
    exec(0, 64'h40, 64'h1, 8'h01);
    exec(2, 64'h48, 64'h2, 8'h01);
    probe(1, 4'd3, 64'h80, 8'h01);
    chk("unknown_iss_ok", 64'(ld_iss_ok_o), 64'd0);
    probe(1, 4'd1, 64'h80, 8'h01);
    chk("prefix_iss_ok", 64'(ld_iss_ok_o), 64'd1);
    probe(1, 4'd3, 64'h80, 8'h01);
    st_vld_i = 1; st_idx_i = 1; st_addr_i = 64'h50; st_data_i = 64'h3; st_bm_i = 8'h01; #1;
    chk("no_bypass_iss_ok", 64'(ld_iss_ok_o), 64'd0);
    tick();
    chk("known_iss_ok", 64'(ld_iss_ok_o), 64'd1);
    probe(0, 4'd0, 64'h0, 8'h00);

    // Branch recovery with committed stores draining in order
    do_reset();
    disp(5);
    for (int i = 0; i < 5; i++) exec(i, 64'h2000 + 64'(8*i), 64'hA0 + 64'(i), 8'hFF);
    chk("rec_tail5", 64'(sq_tail_o), 64'd5);
    retire(2);
    br_recovery_i = 1; br_tail_i = 4'd3; dp_en_i = 1; tick();
    chk("rec_tail3", 64'(sq_tail_o), 64'd3);
    chk("rec_req", 64'(st_req_o), 64'd1);
    chk("rec_first", st_addr_o, 64'h2000);
    ack(1);
    chk("rec_second", st_addr_o, 64'h2008);
    ack(1);
    chk("rec_done", 64'(st_req_o), 64'd0);
    ack(1);
    chk("rec_spurious_ack", 64'(sq_empty_o), 64'd0);

    // Forwarding across the index wrap
    do_reset();
    disp(6);
    for (int i = 0; i < 6; i++) exec(i, 64'h3000 + 64'(8*i), 64'(i), 8'hFF);
    retire(6);
    ack(6);
    disp(4);
    chk("wrapfwd_tail", 64'(sq_tail_o), 64'hA);
    exec(6, 64'h300, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    exec(7, 64'h700, 64'h7777777777777777, 8'hFF);
    exec(0, 64'h800, 64'h8888888888888888, 8'hFF);
    exec(1, 64'h300, 64'hBBBBBBBBBBBBBBBB, 8'hFF);
    probe(1, 4'b1010, 64'h300, 8'hFF);
    chk("wrapfwd_data", fwd_data_o, 64'hBBBBBBBBBBBBBBBB);
    probe(1, 4'b1000, 64'h300, 8'hFF);
    chk("wrapfwd_older", fwd_data_o, 64'hAAAAAAAAAAAAAAAA);
    probe(0, 4'd0, 64'h0, 8'h00);
    retire(2);
    chk("middrain_req", 64'(st_req_o), 64'd1);
    do_reset();
    chk("rst_discard_req", 64'(st_req_o), 64'd0);
    chk("rst_discard_empty", 64'(sq_empty_o), 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sq_fwd_unit.md
# sq_fwd_unit

Parametrised store queue with byte-granular store-to-load forwarding, successor to the fixed-size LSQ store side. It allocates entries in program order at dispatch, captures address, data and byte mask at store execute, and answers one load probe per cycle with youngest-older-store forwarding and partial-overlap detection. Committed stores drain in order to the D-cache over a req/ack handshake; branch recovery restores the tail. Sits between dispatch/ROB, the LSU execute stage and the D-cache controller.

## Interface
- DEPTH, 8, entries; power of 2, ≥2; IDX_W = log2(DEPTH)
- ADDR_W, 64, byte address width; word address = addr[ADDR_W-1:3]
- DATA_W, 64, fixed 64 (8 byte lanes); BM_W = 8
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- dp_en_i  in  1  allocate one entry at tail
- sq_tail_o  out  IDX_W+1  current tail incl. wrap bit; snapshot for loads and branches
- sq_full_o / sq_empty_o  out  1  queue state
- st_vld_i  in  1  store execute write
- st_idx_i  in  IDX_W  entry written
- st_addr_i / st_data_i / st_bm_i  in  ADDR_W / 64 / 8  store address, data, byte mask
- rob_st_retire_en_i  in  1  oldest uncommitted store commits
- br_recovery_i  in  1  mispredict flush
- br_tail_i  in  IDX_W+1  tail to restore
- ld_probe_i  in  1  load probe valid
- ld_pos_i  in  IDX_W+1  load's tail snapshot (stores older than load lie in [head, ld_pos))
- ld_addr_i / ld_bm_i  in  ADDR_W / 8  load address, byte mask
- ld_iss_ok_o  out  1  every older store has a known address
- fwd_hit_o  out  1  youngest overlapping older store fully covers ld_bm_i
- fwd_data_o  out  64  forwarded data (store data unshifted; lanes outside ld_bm_i = 0)
- fwd_conflict_o  out  1  youngest overlapping older store covers ld_bm_i partially
- st_req_o  out  1  drain request, head entry committed
- st_addr_o / st_data_o / st_bm_o  out  ADDR_W / 64 / 8  head entry contents
- st_ack_i  in  1  D-cache accepted head this cycle

## Operation
- Three pointers, each IDX_W+1 bits with wrap MSB: head (oldest, drains), commit (first uncommitted), tail (next free). Invariant head ≤ commit ≤ tail in age.
- Full: idx equal, MSB differ. Empty: head == tail. All arithmetic mod 2·DEPTH.
- Dispatch: dp_en_i and not full → entry[tail].addr_vld cleared, tail+1. dp_en_i while full ignored, no state change.
- Execute: st_vld_i writes addr, data, bm, sets addr_vld at st_idx_i. Same-cycle dp_en_i on the same index: execute write wins.
- Retire: rob_st_retire_en_i and commit ≠ tail → commit+1; else ignored.
- Drain: st_req_o = (head ≠ commit). st_ack_i with st_req_o → head+1, entry addr_vld cleared. st_ack_i without st_req_o ignored.
- Recovery: br_recovery_i → tail = br_tail_i; dp_en_i same cycle ignored. br_tail_i never behind commit (caller guarantees); committed entries untouched. Retire/drain/execute proceed normally in the same cycle.
- ld_iss_ok_o: 0 if any entry in [head, ld_pos_i) has addr_vld = 0; 1 if range empty. Evaluated regardless of ld_probe_i.
- Forwarding (ld_probe_i = 1): candidates = entries in [head, ld_pos_i) with addr_vld, word-address match and (st_bm & ld_bm) ≠ 0. Select youngest candidate by age (closest to ld_pos_i), wrap-aware. Selected bm ⊇ ld_bm → fwd_hit_o = 1, fwd_data_o = data masked by ld_bm. Otherwise fwd_conflict_o = 1, fwd_hit_o = 0. No candidate → both 0, data 0. ld_probe_i = 0 → all fwd outputs 0.
- ld_pos_i == head (in full, including MSB) → no older stores; ld_pos_i with idx equal to head but MSB differing → all DEPTH entries are older.

## Timing
- All probe outputs and st_req_o/st_*_o combinational from current state and inputs; no input-to-st_req_o path except via registers.
- Pointer/entry updates visible the cycle after the enabling edge: dispatch→sq_tail_o +1 cycle; execute→forwardable +1 cycle (no same-cycle execute bypass); retire→st_req_o +1 cycle earliest.
- Drain throughput 1 store/cycle with st_ack_i held high.
- Reset: all pointers 0, all addr_vld 0; sq_empty_o = 1, sq_full_o = 0, st_req_o = 0, sq_tail_o = 0, ld_iss_ok_o = 1 for any ld_pos_i = 0; fwd outputs 0. Reset mid-drain discards all entries without acking.

## Test plan
- Fill/wrap: 8 dispatches → sq_full_o = 1, 9th ignored; retire+ack all 8, 3 more dispatches → sq_tail_o = 0b1011, empty/full correct across wrap.
- Youngest forward: stores idx0 addr 0x100 data 0x11..11 bm 0xFF, idx2 addr 0x100 data 0x22..22 bm 0xFF; probe ld_pos 3, addr 0x100, bm 0x0F → fwd_hit_o = 1, fwd_data_o = 0x0000_0000_2222_2222.
- Partial: single store addr 0x200 bm 0x0F; probe bm 0xFF → fwd_conflict_o = 1, fwd_hit_o = 0; probe bm 0xF0 → both 0.
- Unknown address: dispatch 3, execute idx0, idx2 only; ld_pos 3 → ld_iss_ok_o = 0; ld_pos 1 → 1; execute idx1 → 1 next cycle.
- Recovery: dispatch 5 (tail 5), retire 2, br_recovery_i with br_tail_i = 3 and dp_en_i = 1 → tail 3, commit 2; drain with st_ack_i delivers idx0, idx1 in order, then st_req_o = 0.
- Wrap forwarding: head 6, stores at idx 6 and 1 both addr 0x300, ld_pos 0b1010 → data from idx1.
